iir_biquad_cascade: RTL

- Parametrised successor to the fixed IIR band-pass filter: N_SEC cascaded Direct-Form-I biquad sections with run-time programmable coefficients.
- Sits after the function-generator / ADC path. Takes one signed sample per rising edge of sample strobe f_s (e.g. from clk_40k_gen) and produces one filtered sample.
- Uses a single time-multiplexed multiplier-accumulator, sequenced by an FSM, with rounding and saturation. Adds sample-drop and saturation reporting, which the fixed filter does not have.

---
 rtl/iir_biquad_cascade.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/iir_biquad_cascade.sv
// Purpose: N_SEC cascaded Direct-Form-I biquads sharing one time-multiplexed MAC, with rounding and saturation.
// Latency: start sampled in cycle T -> dout_valid in cycle T+6*N_SEC+1; busy high T+1..T+6*N_SEC.
// Backpressure: none; f_s edges arriving while busy are dropped and flagged on sample_drop.
module iir_biquad_cascade #(
    parameter int DW    = 16,
    parameter int CW    = 16,
    parameter int FRAC  = 14,
    parameter int N_SEC = 2,
    parameter int AW    = 4,
    parameter int ACC_W = 40
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 f_s,
    input  logic signed [DW-1:0] din,
    input  logic                 coef_we,
    input  logic [AW-1:0]        coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 clr_state,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy,
    output logic                 sample_drop,
    output logic                 coef_err,
    output logic                 sat_flag
);

    localparam int NCOEF   = 2 ** AW;
    localparam int NC_USED = 5 * N_SEC;
    localparam int SW      = (N_SEC > 1) ? $clog2(N_SEC) : 1;
    localparam int PW      = DW + CW;

    localparam logic signed [CW-1:0]    COEF_ONE = CW'(1 << FRAC);
    localparam logic signed [ACC_W-1:0] RND      = {{(ACC_W-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [ACC_W-1:0] YMAX     = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] YMIN     = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_WB, S_DONE} state_t;

    // Sequencer and datapath state
    state_t                state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic [SW-1:0]         sec_q, sec_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [DW-1:0]  x_q, x_d;
    logic                  f_s_dly_q, f_s_dly_d;

    // Coefficient table (entries at or above NC_USED are never written)
    logic signed [CW-1:0]  coef_q [NCOEF];
    logic signed [CW-1:0]  coef_d [NCOEF];
    logic signed [CW-1:0]  coef_rst [NCOEF];

    // Per-section delay lines
    logic signed [DW-1:0]  x1_q [N_SEC];
    logic signed [DW-1:0]  x1_d [N_SEC];
    logic signed [DW-1:0]  x2_q [N_SEC];
    logic signed [DW-1:0]  x2_d [N_SEC];
    logic signed [DW-1:0]  y1_q [N_SEC];
    logic signed [DW-1:0]  y1_d [N_SEC];
    logic signed [DW-1:0]  y2_q [N_SEC];
    logic signed [DW-1:0]  y2_d [N_SEC];

    // Registered outputs
    logic signed [DW-1:0]  dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  busy_q, busy_d;
    logic                  sample_drop_q, sample_drop_d;
    logic                  coef_err_q, coef_err_d;
    logic                  sat_flag_q, sat_flag_d;

    // Datapath intermediates
    logic                  start;
    logic [AW-1:0]         coef_idx;
    logic signed [DW-1:0]  data_op;
    logic signed [CW-1:0]  coef_op;
    logic signed [PW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] mac_sum;
    logic signed [ACC_W-1:0] acc_rnd;
    logic signed [ACC_W-1:0] acc_shr;
    logic signed [DW-1:0]  y_sat;
    logic                  y_clip;

    // Reset image of the coefficient table: every used section starts as a pass-through
    always_comb begin
        for (int i = 0; i < NCOEF; i++) begin
            coef_rst[i] = ((i % 5) == 0 && i < NC_USED) ? COEF_ONE : '0;
        end
    end

    // MAC operand selection: k picks the tap, negating the feedback taps
    always_comb begin
        coef_idx = AW'(5 * int'(sec_q) + int'(k_q));
        coef_op  = coef_q[coef_idx];
        case (k_q)
            3'd1:    data_op = x1_q[sec_q];
            3'd2:    data_op = x2_q[sec_q];
            3'd3:    data_op = y1_q[sec_q];
            3'd4:    data_op = y2_q[sec_q];
            default: data_op = x_q;
        endcase
        prod     = data_op * coef_op;
        prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
        acc_base = (k_q == 3'd0) ? '0 : acc_q;
        mac_sum  = (k_q >= 3'd3) ? (acc_base - prod_ext) : (acc_base + prod_ext);
    end

    // Writeback: round half up, arithmetic shift, clip to the output range
    always_comb begin
        acc_rnd = acc_q + RND;
        acc_shr = acc_rnd >>> FRAC;
        y_clip  = 1'b0;
        y_sat   = acc_shr[DW-1:0];
        if (acc_shr > YMAX) begin
            y_sat  = YMAX[DW-1:0];
            y_clip = 1'b1;
        end else if (acc_shr < YMIN) begin
            y_sat  = YMIN[DW-1:0];
            y_clip = 1'b1;
        end
    end

    // Next-state logic for the sequencer, coefficient port and delay lines
    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        sec_d         = sec_q;
        acc_d         = acc_q;
        x_d           = x_q;
        f_s_dly_d     = f_s;
        coef_d        = coef_q;
        x1_d          = x1_q;
        x2_d          = x2_q;
        y1_d          = y1_q;
        y2_d          = y2_q;
        dout_d        = dout_q;
        dout_valid_d  = 1'b0;
        busy_d        = busy_q;
        sample_drop_d = 1'b0;
        coef_err_d    = 1'b0;
        sat_flag_d    = sat_flag_q;

        start = f_s & ~f_s_dly_q;

        // A write in the start cycle lands before the first MAC read of that sample
        if (coef_we) begin
            if (!busy_q && int'(coef_addr) < NC_USED) begin
                coef_d[coef_addr] = coef_data;
            end else begin
                coef_err_d = 1'b1;
            end
        end

        if (start && busy_q) begin
            sample_drop_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                // Clear is committed at the same edge that launches a coincident sample,
                // so that sample sees zero history
                if (clr_state) begin
                    x1_d = '{default: '0};
                    x2_d = '{default: '0};
                    y1_d = '{default: '0};
                    y2_d = '{default: '0};
                end
                if (start) begin
                    x_d     = din;
                    sec_d   = '0;
                    k_d     = '0;
                    busy_d  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = mac_sum;
                if (k_q == 3'd4) begin
                    k_d     = '0;
                    state_d = S_WB;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            S_WB: begin
                x2_d[sec_q] = x1_q[sec_q];
                x1_d[sec_q] = x_q;
                y2_d[sec_q] = y1_q[sec_q];
                y1_d[sec_q] = y_sat;
                x_d         = y_sat;
                if (y_clip) begin
                    sat_flag_d = 1'b1;
                end
                if (int'(sec_q) == N_SEC - 1) begin
                    dout_d       = y_sat;
                    dout_valid_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    sec_d   = sec_q + 1'b1;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            sec_q         <= '0;
            acc_q         <= '0;
            x_q           <= '0;
            f_s_dly_q     <= 1'b0;
            coef_q        <= coef_rst;
            x1_q          <= '{default: '0};
            x2_q          <= '{default: '0};
            y1_q          <= '{default: '0};
            y2_q          <= '{default: '0};
            dout_q        <= '0;
            dout_valid_q  <= 1'b0;
            busy_q        <= 1'b0;
            sample_drop_q <= 1'b0;
            coef_err_q    <= 1'b0;
            sat_flag_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            sec_q         <= sec_d;
            acc_q         <= acc_d;
            x_q           <= x_d;
            f_s_dly_q     <= f_s_dly_d;
            coef_q        <= coef_d;
            x1_q          <= x1_d;
            x2_q          <= x2_d;
            y1_q          <= y1_d;
            y2_q          <= y2_d;
            dout_q        <= dout_d;
            dout_valid_q  <= dout_valid_d;
            busy_q        <= busy_d;
            sample_drop_q <= sample_drop_d;
            coef_err_q    <= coef_err_d;
            sat_flag_q    <= sat_flag_d;
        end
    end

    assign dout        = dout_q;
    assign dout_valid  = dout_valid_q;
    assign busy        = busy_q;
    assign sample_drop = sample_drop_q;
    assign coef_err    = coef_err_q;
    assign sat_flag    = sat_flag_q;

endmodule
